// File: rtl/nn_run_sequencer.sv
// nn_run_sequencer: sequences one inference run of the 4-neuron perceptron
// datapath (parameter load, input load, compute settle, result readout).
// Host bytes arrive over s_valid/s_ready and are turned into per-byte write
// strobes. Results return over m_valid/m_ready.
// Optional build macro SEQ_REUSE_PARAMS_EN adds a reuse_params input that
// skips the parameter load when a complete parameter set is already held.
module nn_run_sequencer #(
   parameter int unsigned N_NEURONS     = 4,
   parameter int unsigned N_PARAMS      = 6,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned DATA_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
`ifdef SEQ_REUSE_PARAMS_EN
   input  logic              reuse_params,
`endif
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              param_we,
   output logic [4:0]        param_addr,
   output logic              inp_we,
   output logic [1:0]        inp_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        sel_state,
   output logic [1:0]        out_sel,
   input  logic [DATA_W-1:0] net_out,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W    = 5;
   localparam int unsigned SET_W    = 4;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned N_PBEATS = N_NEURONS * N_PARAMS;

   localparam logic [CNT_W-1:0] LAST_PARAM  = CNT_W'(N_PBEATS - 1);
   localparam logic [CNT_W-1:0] LAST_INPUT  = CNT_W'(N_NEURONS - 1);
   localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_RESULT = IDX_W'(N_NEURONS - 1);

   localparam logic [1:0] SEL_PARAMS  = 2'b00;
   localparam logic [1:0] SEL_INPUTS  = 2'b01;
   localparam logic [1:0] SEL_HOLD    = 2'b10;
   localparam logic [1:0] SEL_READOUT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LOAD_PARAMS = 3'd1,
      ST_LOAD_INPUTS = 3'd2,
      ST_COMPUTE     = 3'd3,
      ST_READOUT     = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic             kill;

`ifdef SEQ_REUSE_PARAMS_EN
   logic             params_valid_q, params_valid_d;
`endif

   // Abort and reset both suppress any strobe or handshake effect this cycle
   assign kill = abort | reset;

   // State and counter registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         settle_q <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
`ifdef SEQ_REUSE_PARAMS_EN
         params_valid_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
`ifdef SEQ_REUSE_PARAMS_EN
         params_valid_q <= params_valid_d;
`endif
      end
   end

   // Next-state, counter updates and per-state outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      settle_d  = settle_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
`ifdef SEQ_REUSE_PARAMS_EN
      params_valid_d = params_valid_q;
`endif
      s_ready   = 1'b0;
      sel_state = SEL_HOLD;
      out_sel   = '0;
      m_valid   = 1'b0;
      param_we  = 1'b0;
      inp_we    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               cnt_d    = '0;
               settle_d = '0;
               idx_d    = '0;
`ifdef SEQ_REUSE_PARAMS_EN
               if (reuse_params && params_valid_q) begin
                  state_d = ST_LOAD_INPUTS;
               end else begin
                  state_d = ST_LOAD_PARAMS;
               end
`else
               state_d = ST_LOAD_PARAMS;
`endif
            end
         end

         ST_LOAD_PARAMS: begin
            sel_state = SEL_PARAMS;
            s_ready   = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
`ifdef SEQ_REUSE_PARAMS_EN
               params_valid_d = 1'b0;
`endif
            end else if (s_valid && !kill) begin
               param_we = 1'b1;
               if (cnt_q == LAST_PARAM) begin
                  state_d = ST_LOAD_INPUTS;
                  cnt_d   = '0;
`ifdef SEQ_REUSE_PARAMS_EN
                  params_valid_d = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_LOAD_INPUTS: begin
            sel_state = SEL_INPUTS;
            s_ready   = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (s_valid && !kill) begin
               inp_we = 1'b1;
               if (cnt_q == LAST_INPUT) begin
                  state_d  = ST_COMPUTE;
                  cnt_d    = '0;
                  settle_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_COMPUTE: begin
            sel_state = SEL_HOLD;
            if (abort) begin
               state_d  = ST_IDLE;
               settle_d = '0;
            end else if (settle_q == LAST_SETTLE) begin
               state_d  = ST_READOUT;
               settle_d = '0;
               idx_d    = '0;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end

         ST_READOUT: begin
            sel_state = SEL_READOUT;
            out_sel   = idx_q;
            m_valid   = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else if (m_ready) begin
               if (idx_q == LAST_RESULT) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Datapath-facing fields; the address is only meaningful under its strobe
   assign param_addr = cnt_q;
   assign inp_addr   = cnt_q[1:0];
   assign wr_data    = s_data;
   assign m_data     = net_out;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_nn_run_sequencer.sv
// Bench for nn_run_sequencer: table-driven runs with a write-strobe
// scoreboard, plus hand-written abort, reset and reuse sequences.
module tb_nn_run_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, abort, s_valid, m_ready;
   logic [7:0] s_data;
   logic       s_ready, param_we, inp_we, m_valid, busy, done;
   logic [4:0] param_addr;
   logic [1:0] inp_addr, sel_state, out_sel;
   logic [7:0] wr_data, net_out, m_data;
`ifdef SEQ_REUSE_PARAMS_EN
   logic       reuse_params = 1'b0;
`endif

   nn_run_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef SEQ_REUSE_PARAMS_EN
      .reuse_params(reuse_params),
`endif
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .param_we(param_we), .param_addr(param_addr),
      .inp_we(inp_we), .inp_addr(inp_addr), .wr_data(wr_data),
      .sel_state(sel_state), .out_sel(out_sel), .net_out(net_out),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Stand-in datapath: each neuron output is a distinct known byte
   assign net_out = 8'(8'hA0 + {6'b0, out_sel});

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       kind;   // 0 param, 1 input
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   typedef struct {
      logic [7:0] pbase;
      bit         gap;
      bit         poke;
      int         stall_idx;
      int         stall_len;
      int         exp_cycles;
   } run_t;
   run_t runs[3];

   typedef struct {
      logic       st;
      logic       ab;
      logic [1:0] exp_sel;
      logic       exp_busy;
   } idle_t;
   idle_t idles[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every strobe must match the oldest byte the host presented
   always @(negedge clk) begin
      if (param_we && inp_we) chk("both_we", 32'd1, 32'd0);
      if (param_we || inp_we) begin
         if (exp_q.size() == 0) begin
            chk("spurious_we", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("we_kind", 32'(inp_we), 32'(mon_e.kind));
            chk("we_addr", 32'(inp_we ? 5'(inp_addr) : param_addr), 32'(mon_e.addr));
            chk("wr_data", 32'(wr_data), 32'(mon_e.data));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_sel"},    32'(sel_state), 32'd2);
      chk({tag, "_busy"},   32'(busy),      32'd0);
      chk({tag, "_sready"}, 32'(s_ready),   32'd0);
      chk({tag, "_mvalid"}, 32'(m_valid),   32'd0);
      chk({tag, "_done"},   32'(done),      32'd0);
      chk({tag, "_outsel"}, 32'(out_sel),   32'd0);
      chk({tag, "_we"},     32'(param_we | inp_we), 32'd0);
   endtask

   task automatic send_byte(input logic kind, input logic [7:0] d, input logic [4:0] a, input bit gap);
      int  n;
      wr_t e;
      if (gap) begin
         s_valid = 1'b0;
         step();
      end
      s_valid = 1'b1;
      s_data  = d;
      e.kind = kind; e.addr = a; e.data = d;
      exp_q.push_back(e);
      n = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         n++;
         if (n > 20) begin
            chk("s_ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      step();
      s_valid = 1'b0;
   endtask

   task automatic load_params(input logic [7:0] pbase, input bit gap, input bit poke);
      for (int i = 0; i < 24; i++) begin
         if (poke && i == 5) start = 1'b1;
         send_byte(1'b0, 8'(pbase + 8'(i)), 5'(i), gap);
         start = 1'b0;
      end
   endtask

   task automatic load_inputs(input bit gap);
      for (int i = 0; i < 4; i++) send_byte(1'b1, 8'((i + 1) * 16), 5'(i), gap);
   endtask

   task automatic check_compute();
      repeat (2) begin
         @(negedge clk);
         chk("compute_sel",    32'(sel_state), 32'd2);
         chk("compute_sready", 32'(s_ready),   32'd0);
         chk("compute_mvalid", 32'(m_valid),   32'd0);
         step();
      end
   endtask

   task automatic read_one(input int idx, input int stall);
      m_ready = 1'b0;
      repeat (stall) begin
         @(negedge clk);
         chk("stall_mvalid", 32'(m_valid), 32'd1);
         chk("stall_outsel", 32'(out_sel), 32'(idx));
         chk("stall_mdata",  32'(m_data),  32'(8'hA0 + 8'(idx)));
         step();
      end
      m_ready = 1'b1;
      @(negedge clk);
      chk("rd_mvalid", 32'(m_valid),   32'd1);
      chk("rd_sel",    32'(sel_state), 32'd3);
      chk("rd_outsel", 32'(out_sel),   32'(idx));
      chk("rd_mdata",  32'(m_data),    32'(8'hA0 + 8'(idx)));
      step();
      m_ready = 1'b0;
   endtask

   task automatic finish_run(input int unsigned t0, input int exp_cycles, input int stall_idx, input int stall_len);
      check_compute();
      for (int i = 0; i < 4; i++) read_one(i, (i == stall_idx) ? stall_len : 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("run_cycles", 32'(cyc - t0), 32'(exp_cycles));
      chk("idle_busy",  32'(busy), 32'd0);
      step();
      @(negedge clk);
      chk("done_once",   32'(done), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_run(input run_t r);
      int unsigned t0;
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
      load_params(r.pbase, r.gap, r.poke);
      load_inputs(r.gap);
      finish_run(t0, r.exp_cycles, r.stall_idx, r.stall_len);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      runs[0] = '{8'h01, 1'b0, 1'b0, 4, 0, 35};
      runs[1] = '{8'h40, 1'b1, 1'b0, 2, 3, 66};
      runs[2] = '{8'h80, 1'b0, 1'b1, 0, 1, 36};
      idles[0] = '{1'b0, 1'b0, 2'd2, 1'b0};
      idles[1] = '{1'b0, 1'b1, 2'd2, 1'b0};
      idles[2] = '{1'b1, 1'b1, 2'd2, 1'b0};

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
      step(); step();
      check_reset_outputs("reset");
      reset = 1'b0;
      step();

      // IDLE must ignore abort and start+abort
      foreach (idles[k]) begin
         start = idles[k].st;
         abort = idles[k].ab;
         step();
         start = 1'b0;
         abort = 1'b0;
         @(negedge clk);
         chk("idle_sel",    32'(sel_state), 32'(idles[k].exp_sel));
         chk("idle_busy_v", 32'(busy),      32'(idles[k].exp_busy));
         chk("idle_sready", 32'(s_ready),   32'd0);
         step();
      end

      foreach (runs[k]) do_run(runs[k]);

      // Abort on the 10th parameter beat with s_valid high
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 9; i++) send_byte(1'b0, 8'(8'hC0 + 8'(i)), 5'(i), 1'b0);
      s_valid = 1'b1;
      s_data  = 8'hFF;
      abort   = 1'b1;
      @(negedge clk);
      chk("abort_no_we", 32'(param_we), 32'd0);
      step();
      abort   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy),      32'd0);
      chk("abort_sel",  32'(sel_state), 32'd2);
      chk("abort_done", 32'(done),      32'd0);
      step();
      @(negedge clk);
      chk("abort_no_late_done", 32'(done), 32'd0);
      step();
      do_run(runs[0]);

      // Reset during READOUT at idx 1
      start = 1'b1;
      step();
      start = 1'b0;
      load_params(8'h20, 1'b0, 1'b0);
      load_inputs(1'b0);
      check_compute();
      read_one(0, 0);
      @(negedge clk);
      chk("pre_reset_outsel", 32'(out_sel), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_outputs("midrun_reset");
      step();
      do_run(runs[2]);

`ifdef SEQ_REUSE_PARAMS_EN
      begin
         int unsigned t0;
         // Parameters are held from the last complete run: skip straight to inputs
         reuse_params = 1'b1;
         start = 1'b1;
         t0 = cyc;
         step();
         start = 1'b0;
         reuse_params = 1'b0;
         @(negedge clk);
         chk("reuse_sel", 32'(sel_state), 32'd1);
         load_inputs(1'b0);
         finish_run(t0, 11, 4, 0);
         step();

         // Abort during parameter load invalidates the held set
         start = 1'b1;
         step();
         start = 1'b0;
         send_byte(1'b0, 8'h55, 5'd0, 1'b0);
         send_byte(1'b0, 8'h56, 5'd1, 1'b0);
         abort = 1'b1;
         step();
         abort = 1'b0;
         reuse_params = 1'b1;
         start = 1'b1;
         t0 = cyc;
         step();
         start = 1'b0;
         reuse_params = 1'b0;
         @(negedge clk);
         chk("reuse_after_abort_sel", 32'(sel_state), 32'd0);
         load_params(8'h60, 1'b0, 1'b0);
         load_inputs(1'b0);
         finish_run(t0, 35, 4, 0);
         step();
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nn_run_sequencer.md
Name: nn_run_sequencer

Overview:
- Controller that sequences one full inference run of the 4-neuron perceptron datapath: parameter load, input load, compute settle, result readout.
- Accepts a byte stream over a valid/ready handshake and produces per-byte write strobes and addresses for the parameter and input registers.
- Drives the 2-bit datapath phase selector and the output selector, then returns the four neuron outputs over a valid/ready result port.
- Sits between the host byte interface and the neural_network datapath, replacing free-running phase stepping.

Parameters:
- N_NEURONS, 4, number of neurons; also the input count and the result count.
- N_PARAMS, 6, bytes per neuron (w0..w3, bias, threshold); total parameter beats = N_NEURONS*N_PARAMS = 24.
- SETTLE_CYCLES, 2, cycles spent in COMPUTE before readout (range 1..15).
- DATA_W, 8, byte width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the current run
- s_data  in  DATA_W  host byte
- s_valid  in  1  host byte valid
- s_ready  out  1  sequencer accepts byte
- param_we  out  1  parameter write strobe
- param_addr  out  5  parameter index 0..23 (neuron*6 + field)
- inp_we  out  1  input write strobe
- inp_addr  out  2  input index 0..3
- wr_data  out  DATA_W  byte to write (equals s_data)
- sel_state  out  2  datapath phase: 00 params, 01 inputs, 10 compute/hold, 11 readout
- out_sel  out  2  neuron output select
- net_out  in  DATA_W  selected datapath output
- m_data  out  DATA_W  result byte
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on run completion

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset: state IDLE; all counters 0; sel_state=10, out_sel=0; s_ready, m_valid, param_we, inp_we, busy, done all 0.
- Reset mid-run is identical to reset from IDLE. Datapath register contents are not cleared by this block.
- States: IDLE, LOAD_PARAMS, LOAD_INPUTS, COMPUTE, READOUT.
- IDLE: sel_state=10, s_ready=0. start=1 moves to LOAD_PARAMS next cycle with cnt=0.
- LOAD_PARAMS: sel_state=00, s_ready=1.
  - A beat is s_valid&s_ready. On a beat, param_we=1 combinationally, param_addr=cnt, wr_data=s_data, then cnt increments.
  - No beat means no strobe and cnt holds.
  - The beat with cnt=23 moves to LOAD_INPUTS with cnt=0.
- LOAD_INPUTS: sel_state=01, s_ready=1. Same beat rules using inp_we/inp_addr. The beat with cnt=3 moves to COMPUTE with the settle counter at 0.
- COMPUTE: sel_state=10, s_ready=0. After exactly SETTLE_CYCLES cycles in COMPUTE, moves to READOUT with idx=0.
- READOUT: sel_state=11, out_sel=idx, m_data=net_out (combinational), m_valid=1.
  - m_data is stable while m_valid is high and m_ready is low.
  - On m_valid&m_ready, idx increments.
  - The beat with idx=3 moves to IDLE and asserts done for 1 cycle on the following cycle.
- abort=1 in any non-IDLE state: IDLE next cycle, counters cleared, no done, no strobe that cycle. abort has priority over a simultaneous beat.
- start while busy is ignored. start and abort together in IDLE: stay in IDLE.
- Latency, no backpressure: start to first s_ready is 1 cycle; minimum run is 1+24+4+SETTLE_CYCLES+4 cycles.
- Strobes never assert outside their own state. param_we and inp_we are never high together.

Optional Feature:
- Macro: SEQ_REUSE_PARAMS_EN.
- Defined:
  - Adds input port reuse_params (1 bit) and internal flag params_valid.
  - params_valid is set on the 24th parameter beat. It is cleared by reset, and by abort while in LOAD_PARAMS.
  - start with reuse_params=1 and params_valid=1 goes straight from IDLE to LOAD_INPUTS.
  - start with reuse_params=1 and params_valid=0 behaves as a normal start.
- Undefined: port and flag are absent; every run loads parameters.

Test Plan:
- Reset, then start, then 24 back-to-back param bytes 0x01..0x18 -> param_addr 0..23 with matching wr_data, exactly 24 param_we pulses; then 4 input bytes 0x10,0x20,0x30,0x40 -> inp_addr 0..3; COMPUTE lasts 2 cycles; readout of 4 bytes with m_ready=1 -> out_sel 0,1,2,3; done pulses once; total run 35 cycles.
- s_valid toggling every other cycle during loads, and m_ready low for 3 cycles at idx=2 -> cnt advances only on beats; m_data/out_sel held constant while stalled; no extra strobes.
- abort on the 10th param beat, with s_valid high the same cycle -> no param_we that cycle; IDLE next cycle; no done; a new start restarts at param_addr 0.
- Reset asserted during READOUT at idx=1 -> next cycle all outputs at reset values; start pulsed while busy in a later run has no effect.
- With SEQ_REUSE_PARAMS_EN: one full run, then start with reuse_params=1 -> first strobe is inp_we at inp_addr 0 one cycle after start. After an abort in LOAD_PARAMS, reuse_params=1 still loads params from addr 0.
